// File: rtl/lcd_bus_decoder_pkg.sv
// Shared constants, opcode masks and address helpers
// for the passive HD44780 bus decoder.
package lcd_pkg;

  localparam logic [7:0] LCD_SPACE  = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         LINE_LEN   = 16;
  localparam logic [6:0] LINE_END   = 7'h27;

  localparam logic [7:0] M_DDRAM = 8'h80, P_DDRAM = 8'h80;
  localparam logic [7:0] M_CGRAM = 8'hC0, P_CGRAM = 8'h40;
  localparam logic [7:0] M_FUNC  = 8'hE0, P_FUNC  = 8'h20;
  localparam logic [7:0] M_SHIFT = 8'hF0, P_SHIFT = 8'h10;
  localparam logic [7:0] M_DISP  = 8'hF8, P_DISP  = 8'h08;
  localparam logic [7:0] M_ENTRY = 8'hFC, P_ENTRY = 8'h04;
  localparam logic [7:0] M_HOME  = 8'hFE, P_HOME  = 8'h02;
  localparam logic [7:0] M_CLEAR = 8'hFF, P_CLEAR = 8'h01;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } lcd_op_e;

  function automatic lcd_op_e decode_op(
    input logic [7:0] b
  );
    lcd_op_e op;
    op = OP_NOP;
    unique case (1'b1)
      (b & M_DDRAM) == P_DDRAM: op = OP_DDRAM;
      (b & M_CGRAM) == P_CGRAM: op = OP_CGRAM;
      (b & M_FUNC)  == P_FUNC:  op = OP_FUNC;
      (b & M_SHIFT) == P_SHIFT: op = OP_SHIFT;
      (b & M_DISP)  == P_DISP:  op = OP_DISP;
      (b & M_ENTRY) == P_ENTRY: op = OP_ENTRY;
      (b & M_HOME)  == P_HOME:  op = OP_HOME;
      (b & M_CLEAR) == P_CLEAR: op = OP_CLEAR;
      default:                  op = OP_NOP;
    endcase
    return op;
  endfunction

  // 2-line map: 0x00-0x27 and 0x40-0x67, each wrapping into the other
  function automatic logic [6:0] next_addr(
    input logic [6:0] a,
    input logic       inc
  );
    logic [6:0] n;
    if (inc) begin
      if (a[5:0] >= LINE_END[5:0])
        n = a[6] ? LINE1_BASE : LINE2_BASE;
      else
        n = a + 7'd1;
    end else begin
      if (a == LINE1_BASE)
        n = LINE2_BASE + LINE_END;
      else if (a == LINE2_BASE)
        n = LINE_END;
      else
        n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// LCD pin bundle: rs/rw/e/data as driven
// by the LCD driver and snooped by the decoder.
interface lcd_bus_decoder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (
    output lcd_e,
    output lcd_rs,
    output lcd_rw,
    output lcd_data
  );

  modport slave (
    input lcd_e,
    input lcd_rs,
    input lcd_rw,
    input lcd_data
  );
endinterface

// File: rtl/lcd_bus_decoder_strobe_sync.sv
// Pin synchronizer, E-high counter and falling-edge
// strobe detector for the LCD bus.
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  output logic       strobe_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] data_o,
  output logic       short_o
);

  localparam int STG =
    (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [7:0] MINH = 8'(MIN_E_HIGH);

  logic [10:0] sync_q [STG];
  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        e_s, fall, long_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < STG; i++)
        sync_q[i] <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q[0] <= {e_i, rs_i, rw_i, data_i};
      for (int i = 1; i < STG; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STG-1];
      cnt_q  <= cnt_d;
    end
  end

  assign e_s = sync_q[STG-1][10];

  // cnt_q holds the length of the high phase at the fall
  always_comb begin
    cnt_d = '0;
    if (e_s)
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  assign fall     = prev_q[10] & ~e_s;
  assign long_ok  = cnt_q >= MINH;
  assign strobe_o = fall & long_ok;
  assign short_o  = fall & ~long_ok;
  assign rs_o     = prev_q[9];
  assign rw_o     = prev_q[8];
  assign data_o   = prev_q[7:0];

endmodule

// File: rtl/lcd_bus_decoder.sv
// Passive HD44780 bus snooper: decodes writes and
// rebuilds both visible 16-char lines.
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 2
) (
  input  logic                     clk_1MHz,
  input  logic                     resetn,
  lcd_bus_decoder_if.slave         bus_i,
  output logic [8*LINE_LEN-1:0]    o_line1,
  output logic [8*LINE_LEN-1:0]    o_line2,
  output logic [6:0]               o_addr,
  output logic                     o_display_on,
  output logic                     o_update,
  output logic                     o_err
);

  logic       stb, s_rs, s_rw, s_short;
  logic [7:0] s_data;

  lcd_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_E_HIGH (MIN_E_HIGH)
  ) u_sync (
    .clk_i   (clk_1MHz),
    .rst_ni  (resetn),
    .e_i     (bus_i.lcd_e),
    .rs_i    (bus_i.lcd_rs),
    .rw_i    (bus_i.lcd_rw),
    .data_i  (bus_i.lcd_data),
    .strobe_o(stb),
    .rs_o    (s_rs),
    .rw_o    (s_rw),
    .data_o  (s_data),
    .short_o (s_short)
  );

  logic [7:0] mem_q [2*LINE_LEN];
  logic [7:0] mem_d [2*LINE_LEN];
  logic [6:0] addr_q, addr_d;
  logic       id_q, id_d;
  logic       cg_q, cg_d;
  logic       disp_q, disp_d;
  logic       err_q, err_d;
  logic       upd_q, upd_d;
  logic       vis;
  logic [4:0] idx;

  assign vis = addr_q[5:4] == 2'b00;
  assign idx = {addr_q[6], addr_q[3:0]};

  always_comb begin
    mem_d  = mem_q;
    addr_d = addr_q;
    id_d   = id_q;
    cg_d   = cg_q;
    disp_d = disp_q;
    err_d  = err_q | s_short;
    upd_d  = 1'b0;
    if (stb && !s_rw) begin
      if (s_rs) begin
        if (!cg_q) begin
          if (vis && mem_q[idx] != s_data) begin
            mem_d[idx] = s_data;
            upd_d      = 1'b1;
          end
          addr_d = next_addr(addr_q, id_q);
        end
      end else begin
        unique case (decode_op(s_data))
          OP_DDRAM: begin
            addr_d = s_data[6:0];
            cg_d   = 1'b0;
            if (s_data[5:0] > LINE_END[5:0])
              err_d = 1'b1;
          end
          OP_CGRAM: cg_d = 1'b1;
          OP_FUNC: begin
            if (!(s_data[4] && s_data[3]))
              err_d = 1'b1;
          end
          OP_SHIFT: begin
            if (s_data[3])
              err_d = 1'b1;
            else
              addr_d = next_addr(addr_q, s_data[2]);
          end
          OP_DISP: disp_d = s_data[2];
          OP_ENTRY: begin
            id_d = s_data[1];
            if (s_data[0])
              err_d = 1'b1;
          end
          OP_HOME: begin
            addr_d = LINE1_BASE;
            cg_d   = 1'b0;
          end
          OP_CLEAR: begin
            for (int i = 0; i < 2*LINE_LEN; i++)
              mem_d[i] = LCD_SPACE;
            addr_d = LINE1_BASE;
            id_d   = 1'b1;
            cg_d   = 1'b0;
            upd_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (!resetn) begin
      for (int i = 0; i < 2*LINE_LEN; i++)
        mem_q[i] <= LCD_SPACE;
      addr_q <= LINE1_BASE;
      id_q   <= 1'b1;
      cg_q   <= 1'b0;
      disp_q <= 1'b0;
      err_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      addr_q <= addr_d;
      id_q   <= id_d;
      cg_q   <= cg_d;
      disp_q <= disp_d;
      err_q  <= err_d;
      upd_q  <= upd_d;
    end
  end

  for (genvar g = 0; g < LINE_LEN; g++) begin : g_pack
    assign o_line1[8*(LINE_LEN-g)-1 -: 8] = mem_q[g];
    assign o_line2[8*(LINE_LEN-g)-1 -: 8] =
      mem_q[LINE_LEN+g];
  end

  assign o_addr       = addr_q;
  assign o_display_on = disp_q;
  assign o_update     = upd_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed table-driven bench for lcd_bus_decoder
// with hand-written reset and short-pulse sequences.
module tb_lcd_bus_decoder;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] line1, line2;
  logic [6:0]   addr;
  logic         disp, upd, err;

  int checks = 0;
  int errors = 0;

  lcd_bus_decoder_if bus ();

  lcd_bus_decoder #(
    .SYNC_STAGES(2),
    .MIN_E_HIGH (2)
  ) dut (
    .clk_1MHz    (clk),
    .resetn      (resetn),
    .bus_i       (bus),
    .o_line1     (line1),
    .o_line2     (line2),
    .o_addr      (addr),
    .o_display_on(disp),
    .o_update    (upd),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic [6:0] addr;
    logic       upd;
    logic       disp;
  } vec_t;

  vec_t tv[$];

  localparam logic [127:0] SPACES = {16{8'h20}};

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // e high for hi cycles, then watch 6 cycles
  task automatic strobe(input logic rs,
                        input logic rw,
                        input logic [7:0] d,
                        input int hi,
                        output int ucnt,
                        output int upos);
    @(negedge clk);
    bus.lcd_rs   = rs;
    bus.lcd_rw   = rw;
    bus.lcd_data = d;
    bus.lcd_e    = 1'b1;
    repeat (hi) @(negedge clk);
    bus.lcd_e = 1'b0;
    ucnt = 0;
    upos = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (upd) begin
        ucnt++;
        if (upos < 0) upos = i;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic add(input logic rs, input logic rw,
                     input logic [7:0] d,
                     input logic [6:0] a,
                     input logic u, input logic dp);
    vec_t v;
    v.rs = rs; v.rw = rw; v.d = d;
    v.addr = a; v.upd = u; v.disp = dp;
    tv.push_back(v);
  endtask

  initial begin
    int uc, up;
    logic [127:0] e1, e2;

    bus.lcd_e    = 1'b0;
    bus.lcd_rs   = 1'b0;
    bus.lcd_rw   = 1'b0;
    bus.lcd_data = 8'h00;
    resetn       = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_line1", line1, SPACES);
    chk("rst_line2", line2, SPACES);
    chk("rst_addr", 128'(addr), 128'h0);
    chk("rst_disp", 128'(disp), 128'h0);
    chk("rst_upd", 128'(upd), 128'h0);
    chk("rst_err", 128'(err), 128'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    add(0, 0, 8'h38, 7'h00, 0, 0);
    add(0, 0, 8'h0C, 7'h00, 0, 1);
    add(0, 0, 8'h06, 7'h00, 0, 1);
    add(0, 0, 8'h01, 7'h00, 1, 1);
    add(1, 0, "H",   7'h01, 1, 1);
    add(1, 0, "E",   7'h02, 1, 1);
    add(1, 0, "L",   7'h03, 1, 1);
    add(1, 0, "L",   7'h04, 1, 1);
    add(1, 0, "O",   7'h05, 1, 1);
    add(0, 0, 8'hCF, 7'h4F, 0, 1);
    add(1, 0, "A",   7'h50, 1, 1);
    add(1, 0, "B",   7'h51, 0, 1);
    add(0, 0, 8'hA7, 7'h27, 0, 1);
    add(1, 0, "x",   7'h40, 0, 1);
    add(0, 0, 8'h04, 7'h40, 0, 1);
    add(0, 0, 8'h80, 7'h00, 0, 1);
    add(1, 0, "Z",   7'h67, 1, 1);
    add(0, 0, 8'h10, 7'h66, 0, 1);
    add(0, 0, 8'h14, 7'h67, 0, 1);
    add(0, 0, 8'h14, 7'h00, 0, 1);
    add(0, 1, 8'h01, 7'h00, 0, 1);
    add(0, 0, 8'h06, 7'h00, 0, 1);
    add(1, 0, "Z",   7'h01, 0, 1);
    add(0, 0, 8'h02, 7'h00, 0, 1);
    add(0, 0, 8'h08, 7'h00, 0, 0);
    add(0, 0, 8'h0C, 7'h00, 0, 1);

    foreach (tv[i]) begin
      strobe(tv[i].rs, tv[i].rw, tv[i].d, 2, uc, up);
      chk($sformatf("v%0d_addr", i),
          128'(addr), 128'(tv[i].addr));
      chk($sformatf("v%0d_ucnt", i),
          128'(uc), 128'(tv[i].upd ? 1 : 0));
      chk($sformatf("v%0d_upos", i),
          128'(up), 128'(tv[i].upd ? 3 : -1));
      chk($sformatf("v%0d_disp", i),
          128'(disp), 128'(tv[i].disp));
      chk($sformatf("v%0d_err", i),
          128'(err), 128'h0);
    end

    e1 = SPACES;
    e1[127:88] = "ZELLO";
    e2 = SPACES;
    e2[7:0] = "A";
    chk("line1_text", line1, e1);
    chk("line2_text", line2, e2);

    // 1-cycle E pulse is dropped and flagged
    strobe(1, 0, "Q", 1, uc, up);
    chk("short_err", 128'(err), 128'h1);
    chk("short_ucnt", 128'(uc), 128'h0);
    chk("short_addr", 128'(addr), 128'h0);
    chk("short_line1", line1, e1);

    // reset lands while E is high
    @(negedge clk);
    bus.lcd_rs   = 1'b1;
    bus.lcd_rw   = 1'b0;
    bus.lcd_data = "M";
    bus.lcd_e    = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    bus.lcd_e = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_err", 128'(err), 128'h0);
    chk("mid_rst_line1", line1, SPACES);
    chk("mid_rst_line2", line2, SPACES);
    resetn = 1'b1;
    uc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (upd) uc++;
    end
    chk("post_rst_ucnt", 128'(uc), 128'h0);
    chk("post_rst_err", 128'(err), 128'h0);
    chk("post_rst_addr", 128'(addr), 128'h0);
    chk("post_rst_disp", 128'(disp), 128'h0);

    // illegal set-address then wrap to line2
    strobe(0, 0, 8'hB0, 2, uc, up);
    chk("ill_addr", 128'(addr), 128'h30);
    chk("ill_err", 128'(err), 128'h1);
    strobe(1, 0, "k", 2, uc, up);
    chk("ill_wrap", 128'(addr), 128'h40);
    chk("ill_ucnt", 128'(uc), 128'h0);
    chk("ill_line2", line2, SPACES);

    // unsupported function set flags o_err
    do_reset();
    strobe(0, 0, 8'h30, 2, uc, up);
    chk("fset_err", 128'(err), 128'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
